// File: rtl/simon_turn_scheduler_if.sv
// Simon turn scheduler bus: controller phase, both button pads,
// and the pattern/score/status outputs toward the datapath.
interface simon_turn_scheduler_if #(
  parameter int SCORE_W = 4
);
  logic               start;
  logic [2:0]         phase_in;
  logic [3:0]         p0_btn;
  logic [3:0]         p1_btn;
  logic               p0_valid;
  logic               p1_valid;
  logic [3:0]         pat_out;
  logic               pat_valid;
  logic               setter;
  logic [SCORE_W-1:0] score0;
  logic [SCORE_W-1:0] score1;
  logic               force_fail;
  logic               game_over;
  logic               winner;

  modport master (
    output start, phase_in,
    output p0_btn, p1_btn, p0_valid, p1_valid,
    input  pat_out, pat_valid, setter,
    input  score0, score1,
    input  force_fail, game_over, winner
  );

  modport slave (
    input  start, phase_in,
    input  p0_btn, p1_btn, p0_valid, p1_valid,
    output pat_out, pat_valid, setter,
    output score0, score1,
    output force_fail, game_over, winner
  );
endinterface

// File: rtl/simon_turn_scheduler.sv
// Two-player Simon turn scheduler: grants the pattern datapath, swaps roles,
// keeps scores. Define SIMON_TIMEOUT_EN to build the repeat-phase timeout.
module simon_turn_scheduler #(
  parameter int SCORE_W     = 4,
  parameter int TIMEOUT_CYC = 1000
) (
  input logic                 clk,
  input logic                 rst,
  simon_turn_scheduler_if.slave bus
);
  typedef enum logic [2:0] {
    IDLE, SET, WATCH, REPEAT, OVER
  } state_t;

  localparam logic [2:0] PH_IN   = 3'b001;
  localparam logic [2:0] PH_PLAY = 3'b010;
  localparam logic [2:0] PH_REP  = 3'b100;
  localparam logic [2:0] PH_DONE = 3'b111;
  localparam logic [SCORE_W-1:0] SMAX = '1;

  if (TIMEOUT_CYC < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYC must be at least 2");
  end

`ifdef SIMON_TIMEOUT_EN
  localparam int CW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  logic [CW-1:0] cnt;
`endif

  state_t             state;
  logic [3:0]         pat_q;
  logic               pv_q;
  logic               setter_q;
  logic               ff_q;
  logic               go_q;
  logic               win_q;
  logic [SCORE_W-1:0] s0_q;
  logic [SCORE_W-1:0] s1_q;

  logic       phase_ok;
  logic       from_p1;
  logic       press;
  logic [3:0] btn;

  always_comb begin
    phase_ok = 1'b0;
    unique case (bus.phase_in)
      PH_IN, PH_PLAY, PH_REP, PH_DONE: phase_ok = 1'b1;
      default:                         phase_ok = 1'b0;
    endcase
    from_p1 = (state == SET) ? setter_q : ~setter_q;
    btn     = from_p1 ? bus.p1_btn : bus.p0_btn;
    press   = phase_ok
            && (state == SET || state == REPEAT)
            && (from_p1 ? bus.p1_valid : bus.p0_valid);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      pat_q    <= '0;
      pv_q     <= 1'b0;
      setter_q <= 1'b0;
      ff_q     <= 1'b0;
      go_q     <= 1'b0;
      win_q    <= 1'b0;
      s0_q     <= '0;
      s1_q     <= '0;
`ifdef SIMON_TIMEOUT_EN
      cnt      <= '0;
`endif
    end else begin
      pv_q <= press;
      ff_q <= 1'b0;
      if (press) pat_q <= btn;
      unique case (state)
        IDLE, OVER: begin
          if (bus.start) begin
            state    <= SET;
            s0_q     <= '0;
            s1_q     <= '0;
            setter_q <= 1'b0;
            go_q     <= 1'b0;
          end
        end
        SET: begin
          if (bus.phase_in == PH_PLAY) state <= WATCH;
        end
        WATCH: begin
          if (bus.phase_in == PH_REP) begin
            state <= REPEAT;
`ifdef SIMON_TIMEOUT_EN
            cnt   <= '0;
`endif
          end
        end
        REPEAT: begin
          if (bus.phase_in == PH_IN) begin
            state    <= SET;
            setter_q <= ~setter_q;
            // the repeater is the non-setter
            if (setter_q) begin
              if (s0_q != SMAX) s0_q <= s0_q + SCORE_W'(1);
            end else begin
              if (s1_q != SMAX) s1_q <= s1_q + SCORE_W'(1);
            end
          end else if (bus.phase_in == PH_DONE) begin
            state <= OVER;
            go_q  <= 1'b1;
            win_q <= setter_q;
          end
`ifdef SIMON_TIMEOUT_EN
          else if (phase_ok) begin
            if (press) begin
              cnt <= '0;
            end else if (cnt == CW'(TIMEOUT_CYC - 1)) begin
              ff_q  <= 1'b1;
              state <= OVER;
              go_q  <= 1'b1;
              win_q <= setter_q;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.pat_out    = pat_q;
  assign bus.pat_valid  = pv_q;
  assign bus.setter     = setter_q;
  assign bus.score0     = s0_q;
  assign bus.score1     = s1_q;
  assign bus.force_fail = ff_q;
  assign bus.game_over  = go_q;
  assign bus.winner     = win_q;
endmodule

// File: tb/tb_simon_turn_scheduler.sv
// Bench for simon_turn_scheduler: directed table, corner sequences,
// and random stimulus against a game-level reference model.
module tb_simon_turn_scheduler;
  localparam int SW   = 2;
  localparam int TO   = 8;
  localparam int SMAX = 3;

  localparam int M_IDLE  = 0;
  localparam int M_SET   = 1;
  localparam int M_WATCH = 2;
  localparam int M_REP   = 3;
  localparam int M_OVER  = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  simon_turn_scheduler_if #(.SCORE_W(SW)) bus();

  simon_turn_scheduler #(
    .SCORE_W(SW),
    .TIMEOUT_CYC(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  // reference model: game mode, roles, scores, last forwarded press
  int         m_mode;
  int         m_setter;
  int         m_score[2];
  int         m_cnt;
  int         m_win;
  bit         m_pv;
  bit         m_ff;
  bit         m_go;
  logic [3:0] m_po;

  function automatic bit ph_ok(logic [2:0] p);
    return p inside {3'b001, 3'b010, 3'b100, 3'b111};
  endfunction

  task automatic game_over_at(int w);
    m_mode = M_OVER;
    m_go   = 1;
    m_win  = w;
  endtask

  task automatic model_step(bit r, bit s, logic [2:0] ph,
                            bit v0, logic [3:0] b0,
                            bit v1, logic [3:0] b1);
    int who;
    bit hit;
    if (r) begin
      m_mode = M_IDLE; m_setter = 0;
      m_score[0] = 0; m_score[1] = 0;
      m_pv = 0; m_po = 4'h0; m_ff = 0;
      m_go = 0; m_win = 0; m_cnt = 0;
      return;
    end
    who = -1;
    if (ph_ok(ph) && m_mode == M_SET) who = m_setter;
    if (ph_ok(ph) && m_mode == M_REP) who = 1 - m_setter;
    hit  = (who == 0 && v0) || (who == 1 && v1);
    m_pv = hit;
    m_ff = 0;
    if (hit) m_po = (who == 0) ? b0 : b1;
    case (m_mode)
      M_IDLE, M_OVER: begin
        if (s) begin
          m_mode = M_SET; m_setter = 0;
          m_score[0] = 0; m_score[1] = 0;
          m_go = 0;
        end
      end
      M_SET:   if (ph == 3'b010) m_mode = M_WATCH;
      M_WATCH: begin
        if (ph == 3'b100) begin
          m_mode = M_REP;
          m_cnt  = 0;
        end
      end
      M_REP: begin
        if (ph == 3'b001) begin
          who = 1 - m_setter;
          if (m_score[who] < SMAX) m_score[who]++;
          m_setter = 1 - m_setter;
          m_mode   = M_SET;
        end else if (ph == 3'b111) begin
          game_over_at(m_setter);
        end
`ifdef SIMON_TIMEOUT_EN
        else if (ph_ok(ph)) begin
          if (hit) m_cnt = 0;
          else if (m_cnt == TO - 1) begin
            m_ff = 1;
            game_over_at(m_setter);
          end else m_cnt++;
        end
`endif
      end
      default: m_mode = M_IDLE;
    endcase
  endtask

  task automatic check_model(string tag);
    checks++;
    if (bus.pat_valid !== m_pv || bus.pat_out !== m_po ||
        bus.setter !== (m_setter == 1) ||
        bus.score0 !== SW'(m_score[0]) ||
        bus.score1 !== SW'(m_score[1]) ||
        bus.game_over !== m_go || bus.force_fail !== m_ff ||
        (m_go && bus.winner !== (m_win == 1))) begin
      errors++;
      $display("FAIL %s t=%0t: got pv=%b po=%h set=%b s0=%0d s1=%0d go=%b ff=%b win=%b | want pv=%b po=%h set=%0d s0=%0d s1=%0d go=%b ff=%b win=%0d",
               tag, $time, bus.pat_valid, bus.pat_out, bus.setter,
               bus.score0, bus.score1, bus.game_over, bus.force_fail,
               bus.winner, m_pv, m_po, m_setter, m_score[0], m_score[1],
               m_go, m_ff, m_win);
    end
  endtask

  task automatic check_eq(string nm, logic [31:0] got, logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, got, want);
    end
  endtask

  task automatic drive(string tag, bit r, bit s, logic [2:0] ph,
                       bit v0, logic [3:0] b0,
                       bit v1, logic [3:0] b1);
    rst          = r;
    bus.start    = s;
    bus.phase_in = ph;
    bus.p0_valid = v0;
    bus.p0_btn   = b0;
    bus.p1_valid = v1;
    bus.p1_btn   = b1;
    @(posedge clk);
    model_step(r, s, ph, v0, b0, v1, b1);
    #1;
    check_model(tag);
  endtask

  task automatic idle(string tag, logic [2:0] ph);
    drive(tag, 0, 0, ph, 0, 4'h0, 0, 4'h0);
  endtask

  typedef struct {
    bit         st;
    logic [2:0] ph;
    bit         v0;
    logic [3:0] b0;
    bit         v1;
    logic [3:0] b1;
    bit         pv;
    logic [3:0] po;
    bit         set;
    int         s0;
    int         s1;
    bit         go;
    bit         win;
  } vec_t;

  vec_t tbl[14];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n;
    bit seen;
    int r;

    tbl[0]  = '{1, 3'b001, 0, 4'h0, 0, 4'h0, 0, 4'h0, 0, 0, 0, 0, 0};
    tbl[1]  = '{0, 3'b001, 1, 4'h5, 1, 4'h8, 1, 4'h5, 0, 0, 0, 0, 0};
    tbl[2]  = '{0, 3'b001, 0, 4'h0, 0, 4'h0, 0, 4'h0, 0, 0, 0, 0, 0};
    tbl[3]  = '{0, 3'b010, 0, 4'h0, 0, 4'h0, 0, 4'h0, 0, 0, 0, 0, 0};
    tbl[4]  = '{0, 3'b100, 1, 4'h3, 0, 4'h0, 0, 4'h0, 0, 0, 0, 0, 0};
    tbl[5]  = '{0, 3'b100, 1, 4'h1, 1, 4'ha, 1, 4'ha, 0, 0, 0, 0, 0};
    tbl[6]  = '{0, 3'b100, 1, 4'h6, 0, 4'h0, 0, 4'h0, 0, 0, 0, 0, 0};
    tbl[7]  = '{0, 3'b001, 0, 4'h0, 0, 4'h0, 0, 4'h0, 1, 0, 1, 0, 0};
    tbl[8]  = '{0, 3'b001, 1, 4'h2, 1, 4'hf, 1, 4'hf, 1, 0, 1, 0, 0};
    tbl[9]  = '{0, 3'b010, 0, 4'h0, 0, 4'h0, 0, 4'h0, 1, 0, 1, 0, 0};
    tbl[10] = '{0, 3'b100, 0, 4'h0, 0, 4'h0, 0, 4'h0, 1, 0, 1, 0, 0};
    tbl[11] = '{0, 3'b111, 1, 4'h4, 0, 4'h0, 1, 4'h4, 1, 0, 1, 1, 1};
    tbl[12] = '{0, 3'b111, 0, 4'h0, 0, 4'h0, 0, 4'h0, 1, 0, 1, 1, 1};
    tbl[13] = '{1, 3'b001, 0, 4'h0, 0, 4'h0, 0, 4'h0, 0, 0, 0, 0, 0};

    drive("reset0", 1, 0, 3'b000, 0, 4'h0, 0, 4'h0);
    drive("reset1", 1, 1, 3'b001, 1, 4'h7, 1, 4'h7);
    check_eq("reset_outputs",
             32'({bus.pat_valid, bus.pat_out, bus.setter, bus.score0,
                  bus.score1, bus.force_fail, bus.game_over, bus.winner}),
             32'd0);

    foreach (tbl[i]) begin
      drive($sformatf("tbl_model[%0d]", i), 0, tbl[i].st, tbl[i].ph,
            tbl[i].v0, tbl[i].b0, tbl[i].v1, tbl[i].b1);
      checks++;
      if (bus.pat_valid !== tbl[i].pv ||
          (tbl[i].pv && bus.pat_out !== tbl[i].po) ||
          bus.setter !== tbl[i].set ||
          bus.score0 !== SW'(tbl[i].s0) ||
          bus.score1 !== SW'(tbl[i].s1) ||
          bus.game_over !== tbl[i].go ||
          (tbl[i].go && bus.winner !== tbl[i].win)) begin
        errors++;
        $display("FAIL tbl[%0d]: got pv=%b po=%h set=%b s0=%0d s1=%0d go=%b win=%b want pv=%b po=%h set=%b s0=%0d s1=%0d go=%b win=%b",
                 i, bus.pat_valid, bus.pat_out, bus.setter, bus.score0,
                 bus.score1, bus.game_over, bus.winner, tbl[i].pv,
                 tbl[i].po, tbl[i].set, tbl[i].s0, tbl[i].s1, tbl[i].go,
                 tbl[i].win);
      end
    end

    // eight clean rounds: each player repeats four times, scores saturate
    for (int k = 1; k <= 8; k++) begin
      idle("sat_play", 3'b010);
      idle("sat_rep", 3'b100);
      idle("sat_in", 3'b001);
      check_eq($sformatf("sat_score1_r%0d", k), 32'(bus.score1),
               ((k + 1) / 2 > SMAX) ? SMAX : (k + 1) / 2);
      check_eq($sformatf("sat_score0_r%0d", k), 32'(bus.score0),
               (k / 2 > SMAX) ? SMAX : k / 2);
    end

`ifdef SIMON_TIMEOUT_EN
    idle("to_play", 3'b010);
    idle("to_rep", 3'b100);
    n = 0;
    while (!bus.force_fail && n < 20) begin
      idle("to_wait", 3'b100);
      n++;
    end
    check_eq("timeout_cycles", n, TO);
    check_eq("timeout_over", 32'({bus.game_over, bus.winner}), 32'b10);
    idle("to_after", 3'b111);
    check_eq("timeout_single_pulse", 32'(bus.force_fail), 0);

    drive("to_start", 0, 1, 3'b001, 0, 4'h0, 0, 4'h0);
    idle("to_play2", 3'b010);
    idle("to_rep2", 3'b100);
    seen = 0;
    for (int k = 0; k < TO - 1; k++) begin
      idle("to_wait2", 3'b100);
      seen |= bus.force_fail;
    end
    drive("to_press", 0, 0, 3'b100, 0, 4'h0, 1, 4'h9);
    seen |= bus.force_fail;
    check_eq("timeout_press_restart", 32'({seen, bus.pat_valid}), 32'b01);
    n = 0;
    while (!bus.force_fail && n < 20) begin
      idle("to_wait3", 3'b100);
      n++;
    end
    check_eq("timeout_after_press", n, TO);
`else
    idle("nto_play", 3'b010);
    idle("nto_rep", 3'b100);
    seen = 0;
    for (int k = 0; k < 3 * TO; k++) begin
      idle("nto_wait", 3'b100);
      seen |= bus.force_fail | bus.game_over;
    end
    check_eq("no_timeout", 32'(seen), 0);
    idle("nto_done", 3'b111);
`endif

    drive("rst_start", 0, 1, 3'b001, 0, 4'h0, 0, 4'h0);
    drive("rst_set", 0, 0, 3'b001, 1, 4'hc, 0, 4'h0);
    idle("rst_play", 3'b010);
    idle("rst_rep", 3'b100);
    idle("rst_in", 3'b001);
    idle("rst_play2", 3'b010);
    check_eq("rst_pre_score1", 32'(bus.score1), 1);
    drive("rst_mid", 1, 1, 3'b100, 1, 4'hd, 1, 4'he);
    check_eq("rst_mid_outputs",
             32'({bus.pat_valid, bus.pat_out, bus.setter, bus.score0,
                  bus.score1, bus.force_fail, bus.game_over, bus.winner}),
             32'd0);
    drive("rst_idle", 0, 0, 3'b001, 1, 4'h5, 1, 4'h5);
    check_eq("rst_idle_no_fwd", 32'(bus.pat_valid), 0);

    for (int k = 0; k < 3000; k++) begin
      logic [2:0] ph;
      r = $urandom_range(0, 99);
      if (r < 25)      ph = 3'b001;
      else if (r < 50) ph = 3'b010;
      else if (r < 80) ph = 3'b100;
      else if (r < 85) ph = 3'b111;
      else             ph = 3'($urandom_range(0, 7));
      drive("random", ($urandom_range(0, 399) == 0),
            ($urandom_range(0, 19) == 0), ph,
            ($urandom_range(0, 9) < 4), 4'($urandom),
            ($urandom_range(0, 9) < 4), 4'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/simon_turn_scheduler.md
# simon_turn_scheduler

Two-player turn scheduler for the Simon memory game. It sits between the two players' button pads and the shared pattern datapath, and owns which player drives it. It tracks the game controller's phase and grants the datapath to the setter during input and to the other player during repeat. It swaps roles after each successful round, keeps per-player scores, and declares the winner when the game ends.

## Interface
- SCORE_W, 4: width of each player's score counter.
- TIMEOUT_CYC, 1000: idle cycles allowed between repeater presses before forfeit; must be ≥ 2.
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  one-cycle pulse; begins a new game.
- phase_in  in  3  controller phase: 001 input, 010 playback, 100 repeat, 111 done; other codes are invalid.
- p0_btn, p1_btn  in  4 each  player button patterns.
- p0_valid, p1_valid  in  1 each  one-cycle press strobes qualifying p*_btn.
- pat_out  out  4  pattern forwarded to the datapath.
- pat_valid  out  1  one-cycle strobe qualifying pat_out.
- setter  out  1  index of the player currently setting the pattern.
- score0, score1  out  SCORE_W each  rounds successfully repeated by each player.
- force_fail  out  1  one-cycle pulse to the datapath/controller on repeat timeout.
- game_over  out  1  high while in OVER.
- winner  out  1  winning player index; valid while game_over=1.

## Operation
- States: IDLE, SET, WATCH, REPEAT, OVER.
- Reset (any state): state=IDLE, pat_out=0, pat_valid=0, setter=0, score0=score1=0, force_fail=0, game_over=0, winner=0, timeout counter=0.
- IDLE:
  - start → SET.
  - Scores cleared and setter=0 on the transition.
- SET:
  - Presses from player `setter` are forwarded; the other player's presses are dropped.
  - phase_in=010 → WATCH.
- WATCH:
  - All presses dropped.
  - phase_in=100 → REPEAT, and the timeout counter is loaded with 0.
- REPEAT:
  - Presses from player ~setter are forwarded; the setter's presses are dropped.
  - phase_in=001 → SET. The repeater's score increments, saturating at 2^SCORE_W−1, and setter toggles.
  - phase_in=111 → OVER with winner=setter.
  - Timeout → force_fail pulse, then OVER with winner=setter.
- OVER:
  - game_over=1; scores, winner and setter are held.
  - start → SET, with scores cleared and setter=0.
- start is ignored in SET, WATCH and REPEAT.
- Invalid phase_in codes (000, 011, 101, 110): state holds and no presses are forwarded.
- Simultaneous strobes from both players: only the granted player's press is forwarded; the other is dropped silently.
- Multi-hot or zero button patterns are forwarded unchanged; legality checking belongs to the datapath.

## Timing
- Forwarding latency is 1 cycle: a granted p*_valid at cycle N gives pat_valid=1 and pat_out=btn at N+1.
- pat_valid is never high for more than one cycle per strobe.
- Grant is decided by the state at cycle N, not by the next state.
- phase_in is sampled every cycle, and transitions occur on the clock edge after the qualifying value. Example: phase_in=010 at cycle N gives state=WATCH at N+1.
- A press arriving in the same cycle as a phase change is judged against the current state.
- Score increment and setter toggle become visible at the cycle the state enters SET.
- Timeout counter (REPEAT only):
  - Increments each cycle and clears on any granted press.
  - When it reaches TIMEOUT_CYC−1 with no press that cycle, force_fail=1 on the next cycle, and state=OVER that same cycle.
- If phase_in=001 or 111 arrives in the same cycle the timeout expires, phase_in wins and force_fail is not asserted.
- rst asserted mid-game overrides all other inputs in that cycle, including start and pending strobes.

## Configuration
- SIMON_TIMEOUT_EN defined: timeout counter and force_fail are generated as described above.
- SIMON_TIMEOUT_EN undefined: no counter is built, force_fail is tied 0, and REPEAT waits indefinitely for the controller.

## Test plan
- Reset then start, phase_in=001, p0 press btn=0101 → pat_valid=1 and pat_out=0101 one cycle later; simultaneous p1 press btn=1000 produces no output.
- Full round: 001 → 010 → 100 (p1 presses forwarded, p0 dropped) → 001 → score1=1, setter=1, score0=0.
- Failure: during REPEAT with setter=1, phase_in=111 → game_over=1, winner=1, scores held; start → scores 0, setter=0, state SET.
- Saturation, SCORE_W=2: four successful rounds by the same player role → score reaches 3 and stays at 3.
- Timeout with SIMON_TIMEOUT_EN, TIMEOUT_CYC=8: no repeater press for 8 cycles in REPEAT → one force_fail pulse, game_over=1, winner=setter. A press on cycle 7 restarts the count, and no pulse occurs.
- rst asserted in WATCH with p0_valid=1 → all outputs 0 next cycle, state IDLE, no pat_valid.
